// File: rtl/transfer_handler_if.sv
// Bundle of the AHB-side request signals and the generated beat outputs.
// The master side (bus/testbench) drives the request and observes the beats.
// The slave side is the transfer_handler.
interface transfer_handler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              hwrite;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic [DATA_W-1:0] hwdata;
    logic [2:0]        hburst;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] read_addr;
    logic [1:0]        trans_out;

    modport master (
        output addr, hwrite, hrdata, hready, hwdata, hburst, htrans,
        input  read_addr, trans_out
    );

    modport slave (
        input  addr, hwrite, hrdata, hready, hwdata, hburst, htrans,
        output read_addr, trans_out
    );
endinterface

// File: rtl/transfer_handler.sv
// Turns one accepted NONSEQ read request into a sequence of read beats
// (address plus NONSEQ/SEQ transfer type), following the AHB burst type.
// Incrementing bursts step by 4 modulo 2^ADDR_W, wrapping bursts wrap
// inside a 4*len byte window. Outputs are fully registered.
module transfer_handler #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    transfer_handler_if.slave   bus
);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] read_addr_q;
    logic [1:0]        trans_q;
    logic [2:0]        burst_q;
    // Beats still to be emitted after the one currently on the outputs.
    logic [4:0]        beats_left_q;

    logic              accept_d;
    logic [ADDR_W-1:0] start_addr_d;
    logic [4:0]        first_left_d;
    logic [ADDR_W-1:0] step_addr_d;
    logic [ADDR_W-1:0] wrap_mask_d;
    logic              is_wrap_d;
    logic [ADDR_W-1:0] next_addr_d;

    // Read and write data pass straight through the fabric; this block
    // only generates addresses, so the data buses are deliberately sunk.
    logic [DATA_W-1:0] unused_data;
    assign unused_data = bus.hrdata ^ bus.hwdata;

    // Number of beats for each burst encoding (plain INCR is fixed at 4).
    function automatic logic [4:0] burst_len(input logic [2:0] b);
        logic [4:0] len;
        case (b)
            3'b000:                 len = 5'd1;
            3'b001, 3'b010, 3'b011: len = 5'd4;
            3'b100, 3'b101:         len = 5'd8;
            default:                len = 5'd16;
        endcase
        return len;
    endfunction

    // Request decode and next-beat address arithmetic.
    always_comb begin
        accept_d     = (bus.htrans == HT_NONSEQ) && !bus.hwrite;
        start_addr_d = {bus.addr[ADDR_W-1:2], 2'b00};
        first_left_d = burst_len(bus.hburst) - 5'd1;
        step_addr_d  = read_addr_q + ADDR_W'(4);
        wrap_mask_d  = (ADDR_W'(burst_len(burst_q)) << 2) - ADDR_W'(1);
        // WRAP4/8/16 are the even, non-SINGLE encodings.
        is_wrap_d    = (burst_q[0] == 1'b0) && (burst_q != 3'b000);
        if (is_wrap_d) begin
            next_addr_d = (read_addr_q & ~wrap_mask_d) | (step_addr_d & wrap_mask_d);
        end else begin
            next_addr_d = step_addr_d;
        end
    end

    // Burst FSM with registered beat outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            read_addr_q  <= '0;
            trans_q      <= HT_IDLE;
            burst_q      <= 3'b000;
            beats_left_q <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        state_q      <= S_BURST;
                        read_addr_q  <= start_addr_d;
                        trans_q      <= HT_NONSEQ;
                        burst_q      <= bus.hburst;
                        beats_left_q <= first_left_d;
                    end
                end
                S_BURST: begin
                    // htrans/addr are not looked at mid-burst except on the
                    // edge that completes the last beat (back-to-back start).
                    if (bus.hready) begin
                        if (beats_left_q == 5'd0) begin
                            if (accept_d) begin
                                state_q      <= S_BURST;
                                read_addr_q  <= start_addr_d;
                                trans_q      <= HT_NONSEQ;
                                burst_q      <= bus.hburst;
                                beats_left_q <= first_left_d;
                            end else begin
                                state_q      <= S_IDLE;
                                read_addr_q  <= '0;
                                trans_q      <= HT_IDLE;
                            end
                        end else begin
                            read_addr_q  <= next_addr_d;
                            trans_q      <= HT_SEQ;
                            beats_left_q <= beats_left_q - 5'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    read_addr_q <= '0;
                    trans_q     <= HT_IDLE;
                end
            endcase
        end
    end

    assign bus.read_addr = read_addr_q;
    assign bus.trans_out = trans_q;

endmodule

// File: tb/tb_transfer_handler.sv
// Bench for transfer_handler: table of single-request vectors plus
// hand-written sequences for wait states, back-to-back and reset.
module tb_transfer_handler;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam int NV = 9;

    logic clk;
    logic rstn;

    transfer_handler_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    transfer_handler #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [1:0]        htrans;
        logic              hwrite;
        logic [2:0]        hburst;
        logic [31:0]       addr;
        int                n;
        logic [15:0][31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  t;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    int   total;
    int   bad;

    task automatic push(input logic [31:0] a, input logic [1:0] t);
        exp_t e;
        e.a = a;
        e.t = t;
        sb.push_back(e);
    endtask

    task automatic check(input string nm);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, read_addr=%h trans=%b", nm, bus.read_addr, bus.trans_out);
        end else begin
            e = sb.pop_front();
            if (bus.read_addr !== e.a || bus.trans_out !== e.t) begin
                bad++;
                $display("FAIL %s: got read_addr=%h trans=%b, expected read_addr=%h trans=%b",
                         nm, bus.read_addr, bus.trans_out, e.a, e.t);
            end else begin
                $display("ok   %s: read_addr=%h trans=%b", nm, bus.read_addr, bus.trans_out);
            end
        end
    endtask

    task automatic drive(input logic [1:0] ht, input logic wr, input logic [2:0] hb, input logic [31:0] a);
        bus.htrans = ht;
        bus.hwrite = wr;
        bus.hburst = hb;
        bus.addr   = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        // Vector table
        for (int v = 0; v < NV; v++) vecs[v].exp = '0;
        vecs[0].name = "wrap4_1008";  vecs[0].htrans = T_NONSEQ; vecs[0].hwrite = 0; vecs[0].hburst = 3'b010;
        vecs[0].addr = 32'h0000_1008; vecs[0].n = 4;
        vecs[0].exp[0] = 32'h1008; vecs[0].exp[1] = 32'h100C; vecs[0].exp[2] = 32'h1000; vecs[0].exp[3] = 32'h1004;
        vecs[1].name = "incr4_wrap32"; vecs[1].htrans = T_NONSEQ; vecs[1].hwrite = 0; vecs[1].hburst = 3'b011;
        vecs[1].addr = 32'hFFFF_FFF8; vecs[1].n = 4;
        vecs[1].exp[0] = 32'hFFFF_FFF8; vecs[1].exp[1] = 32'hFFFF_FFFC; vecs[1].exp[2] = 32'h0; vecs[1].exp[3] = 32'h4;
        vecs[2].name = "write_ign";   vecs[2].htrans = T_NONSEQ; vecs[2].hwrite = 1; vecs[2].hburst = 3'b011;
        vecs[2].addr = 32'h0000_3000; vecs[2].n = 0;
        vecs[3].name = "single_4003"; vecs[3].htrans = T_NONSEQ; vecs[3].hwrite = 0; vecs[3].hburst = 3'b000;
        vecs[3].addr = 32'h0000_4003; vecs[3].n = 1;
        vecs[3].exp[0] = 32'h4000;
        vecs[4].name = "incr_5000";   vecs[4].htrans = T_NONSEQ; vecs[4].hwrite = 0; vecs[4].hburst = 3'b001;
        vecs[4].addr = 32'h0000_5000; vecs[4].n = 4;
        vecs[4].exp[0] = 32'h5000; vecs[4].exp[1] = 32'h5004; vecs[4].exp[2] = 32'h5008; vecs[4].exp[3] = 32'h500C;
        vecs[5].name = "wrap8_6018";  vecs[5].htrans = T_NONSEQ; vecs[5].hwrite = 0; vecs[5].hburst = 3'b100;
        vecs[5].addr = 32'h0000_6018; vecs[5].n = 8;
        vecs[5].exp[0] = 32'h6018; vecs[5].exp[1] = 32'h601C; vecs[5].exp[2] = 32'h6000; vecs[5].exp[3] = 32'h6004;
        vecs[5].exp[4] = 32'h6008; vecs[5].exp[5] = 32'h600C; vecs[5].exp[6] = 32'h6010; vecs[5].exp[7] = 32'h6014;
        vecs[6].name = "seq_ign";     vecs[6].htrans = T_SEQ;    vecs[6].hwrite = 0; vecs[6].hburst = 3'b011;
        vecs[6].addr = 32'h0000_7000; vecs[6].n = 0;
        vecs[7].name = "incr8_8000";  vecs[7].htrans = T_NONSEQ; vecs[7].hwrite = 0; vecs[7].hburst = 3'b101;
        vecs[7].addr = 32'h0000_8000; vecs[7].n = 8;
        for (int k = 0; k < 8; k++) vecs[7].exp[k] = 32'h8000 + 32'(4 * k);
        vecs[8].name = "wrap16_9034"; vecs[8].htrans = T_NONSEQ; vecs[8].hwrite = 0; vecs[8].hburst = 3'b110;
        vecs[8].addr = 32'h0000_9034; vecs[8].n = 16;
        vecs[8].exp[0]  = 32'h9034; vecs[8].exp[1]  = 32'h9038; vecs[8].exp[2]  = 32'h903C; vecs[8].exp[3]  = 32'h9000;
        vecs[8].exp[4]  = 32'h9004; vecs[8].exp[5]  = 32'h9008; vecs[8].exp[6]  = 32'h900C; vecs[8].exp[7]  = 32'h9010;
        vecs[8].exp[8]  = 32'h9014; vecs[8].exp[9]  = 32'h9018; vecs[8].exp[10] = 32'h901C; vecs[8].exp[11] = 32'h9020;
        vecs[8].exp[12] = 32'h9024; vecs[8].exp[13] = 32'h9028; vecs[8].exp[14] = 32'h902C; vecs[8].exp[15] = 32'h9030;

        // Reset state, checked before any clock edge
        rstn = 1'b0;
        bus.hready = 1'b1;
        bus.hrdata = '0;
        bus.hwdata = '0;
        drive(T_IDLE, 1'b0, 3'b000, 32'h0);
        #1;
        push(32'h0, T_IDLE);
        check("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Table-driven single requests
        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].htrans, vecs[v].hwrite, vecs[v].hburst, vecs[v].addr);
            bus.hready = 1'b1;
            for (int k = 0; k < vecs[v].n; k++) push(vecs[v].exp[k], (k == 0) ? T_NONSEQ : T_SEQ);
            push(32'h0, T_IDLE);
            push(32'h0, T_IDLE);
            while (sb.size() > 0) begin
                @(negedge clk);
                drive(T_IDLE, 1'b0, 3'b000, 32'h0);
                check(vecs[v].name);
            end
        end

        // Wait states, with a stray NONSEQ mid-burst that must be ignored
        drive(T_NONSEQ, 1'b0, 3'b010, 32'h2000);
        push(32'h2000, T_NONSEQ);
        @(negedge clk); drive(T_IDLE, 1'b0, 3'b000, 32'h0); check("ws_b1");
        push(32'h2004, T_SEQ);
        @(negedge clk); check("ws_b2"); bus.hready = 1'b0;
        push(32'h2004, T_SEQ);
        @(negedge clk); check("ws_hold1"); drive(T_NONSEQ, 1'b0, 3'b011, 32'hC000);
        push(32'h2004, T_SEQ);
        @(negedge clk); check("ws_hold2"); bus.hready = 1'b1; drive(T_IDLE, 1'b0, 3'b000, 32'h0);
        push(32'h2008, T_SEQ);
        push(32'h200C, T_SEQ);
        push(32'h0, T_IDLE);
        while (sb.size() > 0) begin
            @(negedge clk);
            check("ws_tail");
        end

        // Back-to-back: new NONSEQ on the edge that completes the last beat
        drive(T_NONSEQ, 1'b0, 3'b010, 32'hA004);
        push(32'hA004, T_NONSEQ);
        push(32'hA008, T_SEQ);
        push(32'hA00C, T_SEQ);
        @(negedge clk); drive(T_IDLE, 1'b0, 3'b000, 32'h0); check("b2b_a");
        @(negedge clk); check("b2b_a");
        @(negedge clk); check("b2b_a");
        push(32'hA000, T_SEQ);
        @(negedge clk); check("b2b_a_last"); drive(T_NONSEQ, 1'b0, 3'b011, 32'hB000);
        push(32'hB000, T_NONSEQ);
        push(32'hB004, T_SEQ);
        push(32'hB008, T_SEQ);
        push(32'hB00C, T_SEQ);
        push(32'h0, T_IDLE);
        @(negedge clk); drive(T_IDLE, 1'b0, 3'b000, 32'h0); check("b2b_b");
        while (sb.size() > 0) begin
            @(negedge clk);
            check("b2b_b");
        end

        // Reset during beat 2 of WRAP8
        drive(T_NONSEQ, 1'b0, 3'b100, 32'h6000);
        push(32'h6000, T_NONSEQ);
        @(negedge clk); drive(T_IDLE, 1'b0, 3'b000, 32'h0); check("rst_b1");
        push(32'h6004, T_SEQ);
        @(negedge clk); check("rst_b2");
        #2 rstn = 1'b0;
        #1;
        push(32'h0, T_IDLE);
        check("rst_async");
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(32'h0, T_IDLE);
            @(negedge clk);
            check("rst_after");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/transfer_handler.md
TRANSFER_HANDLER -- requirements
Module: transfer_handler

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port addr, input, ADDR_W, AHB request address (HADDR).
REQ-006 SHALL have port hwrite, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port hrdata, input, DATA_W, read data; no effect on outputs.
REQ-008 SHALL have port hready, input, 1, 1 = current beat completes this cycle.
REQ-009 SHALL have port hwdata, input, DATA_W, write data; no effect on outputs.
REQ-010 SHALL have port hburst, input, 3, AHB burst type.
REQ-011 SHALL have port htrans, input, 2, AHB transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-012 SHALL have port read_addr, output, ADDR_W, registered address of the current generated beat.
REQ-013 SHALL have port trans_out, output, 2, registered transfer type of the current generated beat; same encoding as htrans.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and BURST.
REQ-015 In IDLE, a request SHALL be accepted at a rising edge where htrans==NONSEQ and hwrite==0. Every other htrans value, and all writes, SHALL be ignored.
REQ-016 On acceptance the block SHALL capture the following and enter BURST; in the next cycle read_addr = start address and trans_out = NONSEQ:
- start address = addr with bits[1:0] forced to 0
- hburst
- beat count
REQ-017 Beat length SHALL follow hburst:
- 000 SINGLE = 1
- 001 INCR = 4 (fixed)
- 010 WRAP4 / 011 INCR4 = 4
- 100 WRAP8 / 101 INCR8 = 8
- 110 WRAP16 / 111 INCR16 = 16
REQ-018 In BURST, a beat SHALL advance only at a rising edge with hready==1. With hready==0, read_addr and trans_out SHALL hold.
REQ-019 Every beat after the first SHALL drive trans_out = SEQ.
REQ-020 Address step for incrementing bursts SHALL be next = read_addr + 4, modulo 2^ADDR_W, with no 1KB boundary check.
REQ-021 Wrapping bursts SHALL use mask = 4*len-1 and next = (read_addr & ~mask) | ((read_addr+4) & mask).
REQ-022 When the last beat completes with hready==1, the FSM SHALL return to IDLE. In the next cycle trans_out = IDLE and read_addr = 0.
REQ-023 A NONSEQ arriving on the same edge the last beat completes SHALL be accepted. The next cycle SHALL show the new start address with NONSEQ.
REQ-024 htrans and addr SHALL be ignored while in BURST; no abort and no restart.
REQ-025 In IDLE, outputs SHALL be read_addr = 0 and trans_out = IDLE (00).

Reset
REQ-026 rstn low SHALL immediately, without waiting for clk, force IDLE state, read_addr = 0, trans_out = 00 and the beat counter to 0.
REQ-027 Reset asserted mid-burst SHALL discard the burst. After rstn rises, no beat SHALL be emitted until a new NONSEQ read is accepted.

Verification
REQ-028 WRAP4 stall-free read: hburst=010, addr=0x0000_1008, NONSEQ for 1 cycle, hready=1 -> outputs shall be 0x1008/NONSEQ, 0x100C/SEQ, 0x1000/SEQ, 0x1004/SEQ, then 0/IDLE.
REQ-029 INCR4 read: hburst=011, addr=0xFFFF_FFF8 -> outputs shall be 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004, with address wrap mod 2^32.
REQ-030 Wait states: WRAP4 at 0x2000 with hready low for the 2 cycles after beat 1 -> read_addr shall hold 0x2004/SEQ for 3 cycles, then the burst shall finish normally.
REQ-031 Write ignored: hwrite=1 with NONSEQ at 0x3000 -> trans_out shall stay IDLE and read_addr shall stay 0.
REQ-032 SINGLE with misaligned address: hburst=000, addr=0x4003 -> one beat 0x4000/NONSEQ, then IDLE.
REQ-033 Reset mid-burst: rstn low during beat 2 of WRAP8 -> outputs shall go to 0/IDLE asynchronously, with no further beats after rstn rises.
